// File: rtl/input_debounce_pkg.sv
// Shared definitions for the pin-input debounce family: FSM state encodings and glitch counter limits.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package input_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        CHK_HIGH  = 2'd1,
        IDLE_HIGH = 2'd2,
        CHK_LOW   = 2'd3
    } state_t;

    localparam int              GLITCH_CNT_W   = 8;
    localparam logic [GLITCH_CNT_W-1:0] GLITCH_CNT_MAX = '1;

endpackage

// File: rtl/input_debounce_sync_chain.sv
// Multi-flop synchroniser bringing an asynchronous level into the clock domain.
// Latency: STAGES clocks from capture to q.
// Backpressure: none, free-running.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/input_debounce.sv
// Synchronise and debounce a raw pin level; optional abort counter under DEBOUNCE_GLITCH_CNT_EN.
// Latency: dout follows SYNC_STAGES+DEBOUNCE_CYCLES clocks after the first sync flop captures a new level.
// Backpressure: none, free-running level path.
module input_debounce
    import input_debounce_pkg::*;
#(
    parameter  int SYNC_STAGES     = 2,
    parameter  int DEBOUNCE_CYCLES = 4,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic                    clock,
    input  logic                    rst,
    input  logic                    din_async,
    output logic                    dout,
`ifdef DEBOUNCE_GLITCH_CNT_EN
    output logic [GLITCH_CNT_W-1:0] glitch_cnt,
`endif
    output logic                    busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic       s;
    state_t     state;
    logic [CNT_W-1:0] cnt;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clock (clock),
        .rst   (rst),
        .d     (din_async),
        .q     (s)
    );

    // Any sample back at the old level during a check throws away all accumulated credit.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state <= IDLE_LOW;
            cnt   <= '0;
            dout  <= 1'b0;
        end else begin
            case (state)
                IDLE_LOW: begin
                    cnt <= '0;
                    if (s) state <= CHK_HIGH;
                end
                CHK_HIGH: begin
                    if (!s) begin
                        state <= IDLE_LOW;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE_HIGH;
                        dout  <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                IDLE_HIGH: begin
                    cnt <= '0;
                    if (!s) state <= CHK_LOW;
                end
                CHK_LOW: begin
                    if (s) begin
                        state <= IDLE_HIGH;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE_LOW;
                        dout  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE_LOW;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign busy = (state == CHK_HIGH) || (state == CHK_LOW);

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic abort;

    assign abort = ((state == CHK_HIGH) && !s) || ((state == CHK_LOW) && s);

    // Saturating so a noisy pin can never make the count look small again.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            glitch_cnt <= '0;
        end else if (abort && (glitch_cnt != GLITCH_CNT_MAX)) begin
            glitch_cnt <= glitch_cnt + GLITCH_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_input_debounce.sv
// Directed bench for input_debounce with a run-length reference model checked every cycle.
module tb_input_debounce;
    import input_debounce_pkg::*;

    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic clock = 1'b0;
    logic rst   = 1'b1;
    logic din_async = 1'b1;
    logic dout;
    logic busy;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_cnt;
`endif

    int checks = 0;
    int errors = 0;

    input_debounce #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clock      (clock),
        .rst        (rst),
        .din_async  (din_async),
        .dout       (dout),
`ifdef DEBOUNCE_GLITCH_CNT_EN
        .glitch_cnt (glitch_cnt),
`endif
        .busy       (busy)
    );

    always #10 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the FSM sees the pin SYNC edges late; dout flips after DEB+1
    // consecutive differing samples, and a matching sample mid-run is an abort.
    bit din_hist[$];
    int m_run   = 0;
    bit m_dout  = 1'b0;
    int m_glitch = 0;

    always @(posedge clock or posedge rst) begin
        if (rst) begin
            din_hist.delete();
            m_run    = 0;
            m_dout   = 1'b0;
            m_glitch = 0;
        end else begin
            bit s_m;
            din_hist.push_back(din_async);
            s_m = (din_hist.size() > SYNC) ? din_hist[din_hist.size() - 1 - SYNC] : 1'b0;
            if (din_hist.size() > SYNC + 1) void'(din_hist.pop_front());
            if (s_m != m_dout) begin
                m_run++;
                if (m_run == DEB + 1) begin
                    m_dout = s_m;
                    m_run  = 0;
                end
            end else begin
                if (m_run > 0 && m_glitch < 255) m_glitch++;
                m_run = 0;
            end
        end
    end

    always @(negedge clock) begin
        chk("cyc_dout", 32'(dout), 32'(m_dout));
        chk("cyc_busy", 32'(busy), 32'(m_run > 0));
`ifdef DEBOUNCE_GLITCH_CNT_EN
        chk("cyc_glitch_cnt", 32'(glitch_cnt), 32'(m_glitch));
`endif
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Counts edges after the capture edge until dout reaches lvl, and busy samples on the way.
    task automatic measure(input logic lvl, output int lat, output int nb);
        @(posedge clock);
        lat = 0;
        nb  = 0;
        while (lat < 20) begin
            @(posedge clock);
            #1;
            lat++;
            if (busy) nb++;
            if (dout === lvl) break;
        end
    endtask

    task automatic pulse(input int w, output bit rose);
        @(negedge clock);
        din_async = 1'b1;
        repeat (w) @(negedge clock);
        din_async = 1'b0;
        rose = 1'b0;
        repeat (14) begin
            @(negedge clock);
            if (dout) rose = 1'b1;
        end
    endtask

    initial begin
        int lat, nb, k;
        bit rose;

        #5;
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        #18 rst = 1'b0;

        measure(1'b1, lat, nb);
        chk("post_rst_rise_lat", 32'(lat), 32'd6);
        chk("post_rst_busy_cycles", 32'(nb), 32'd4);

        repeat (10) @(negedge clock);
        din_async = 1'b0;
        measure(1'b0, lat, nb);
        chk("fall_lat", 32'(lat), 32'd6);
        chk("fall_busy_cycles", 32'(nb), 32'd4);

        repeat (10) @(negedge clock);
        din_async = 1'b1;
        measure(1'b1, lat, nb);
        chk("rise_lat", 32'(lat), 32'd6);
        chk("rise_busy_cycles", 32'(nb), 32'd4);

        repeat (10) @(negedge clock);
        din_async = 1'b0;
        measure(1'b0, lat, nb);
        chk("fall2_lat", 32'(lat), 32'd6);

        pulse(3, rose);
        chk("glitch3_no_rise", 32'(rose), 32'd0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        chk("glitch3_cnt", 32'(glitch_cnt), 32'd1);
`endif
        pulse(4, rose);
        chk("width4_no_rise", 32'(rose), 32'd0);
        pulse(5, rose);
        chk("width5_rise", 32'(rose), 32'd1);
        chk("width5_back_low", 32'(dout), 32'd0);

        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            din_async = 1'b1;
            repeat (2) @(negedge clock);
            din_async = 1'b0;
            @(negedge clock);
        end
        repeat (4) @(negedge clock);
        chk("sat_dout_low", 32'(dout), 32'd0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        chk("sat_glitch_cnt", 32'(glitch_cnt), 32'd255);
`endif

        @(negedge clock);
        din_async = 1'b1;
        measure(1'b1, lat, nb);
        chk("pre_midq_rise_lat", 32'(lat), 32'd6);
        repeat (3) @(negedge clock);
        din_async = 1'b0;
        k = 0;
        while (!(busy && dut.cnt == 2) && k < 40) begin
            @(negedge clock);
            k++;
        end
        chk("midq_reached", 32'(k < 40), 32'd1);
        chk("midq_dout_before", 32'(dout), 32'd1);
        #3 rst = 1'b1;
        #1;
        chk("midq_rst_dout", 32'(dout), 32'd0);
        chk("midq_rst_busy", 32'(busy), 32'd0);
        chk("midq_rst_cnt", 32'(dut.cnt), 32'd0);
        chk("midq_rst_state", 32'(dut.state), 32'(IDLE_LOW));
`ifdef DEBOUNCE_GLITCH_CNT_EN
        chk("midq_rst_glitch_cnt", 32'(glitch_cnt), 32'd0);
`endif
        repeat (2) @(negedge clock);
        din_async = 1'b1;
        rst = 1'b0;
        measure(1'b1, lat, nb);
        chk("requal_rise_lat", 32'(lat), 32'd6);
        chk("requal_busy_cycles", 32'(nb), 32'd4);

        repeat (5) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
